// File: rtl/nlm_pkg.sv
// nlm_pkg: shared constants and helpers for the NLM weight PE.
package nlm_pkg;
  localparam int LUT_STEPS = 16;
  localparam int THR_OFS = 10;
  localparam logic [7:0] WTAB [LUT_STEPS] = '{8'd255, 8'd251, 8'd236, 8'd201, 8'd163, 8'd125, 8'd93, 8'd67,
                                             8'd47, 8'd33, 8'd22, 8'd15, 8'd10, 8'd7, 8'd5, 8'd3};
  function automatic int dist_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction
  function automatic int thr_ofs(input int k);
    return THR_OFS + k;
  endfunction
endpackage

// File: rtl/nlm_row_ssd.sv
// nlm_row_ssd: combinational sum of squared absolute differences across one patch row.
module nlm_row_ssd #(
  parameter int DATA_WIDTH = 12,
  parameter int PATCH_W = 5,
  parameter int OUT_W = 29
) (
  input  logic [PATCH_W*DATA_WIDTH-1:0] ref_row_i,
  input  logic [PATCH_W*DATA_WIDTH-1:0] srh_row_i,
  output logic [OUT_W-1:0]              ssd_o
);
  localparam int SQ_W = 2 * DATA_WIDTH;
  logic [DATA_WIDTH-1:0] diff [PATCH_W];
  logic [SQ_W-1:0] sq [PATCH_W];
  for (genvar i = 0; i < PATCH_W; i++) begin : g_elem
    logic [DATA_WIDTH-1:0] a, b;
    assign a = ref_row_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign b = srh_row_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign diff[i] = a > b ? a - b : b - a;
    assign sq[i] = SQ_W'(diff[i]) * SQ_W'(diff[i]);
  end
  always_comb begin
    ssd_o = '0;
    for (int k = 0; k < PATCH_W; k++) ssd_o = ssd_o + OUT_W'(sq[k]);
  end
endmodule

// File: rtl/nlm_pe_stream.sv
// nlm_pe_stream: streams patch rows, accumulates SSD and maps it to a Gaussian weight
// through a threshold LUT scaled by the runtime sigma^2.
module nlm_pe_stream import nlm_pkg::*; #(
  parameter int DATA_WIDTH = 12,
  parameter int PATCH_W = 5,
  parameter int PATCH_H = 5,
  parameter int WEIGHT_WIDTH = 8,
  parameter int KS_WIDTH = 16,
  parameter int CENTER_MODE = 0
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [KS_WIDTH-1:0]                              cfg_ksigma,
  input  logic                                             s_valid,
  output logic                                             s_ready,
  input  logic [PATCH_W*DATA_WIDTH-1:0]                    s_ref_row,
  input  logic [PATCH_W*DATA_WIDTH-1:0]                    s_srh_row,
  input  logic [DATA_WIDTH-1:0]                            s_pix,
  output logic                                             m_valid,
  input  logic                                             m_ready,
  output logic [WEIGHT_WIDTH-1:0]                          m_weight,
  output logic [DATA_WIDTH+WEIGHT_WIDTH-1:0]               m_wpix,
  output logic [dist_width(DATA_WIDTH, PATCH_W*PATCH_H)-1:0] m_dist
);
  localparam int N = PATCH_W * PATCH_H;
  localparam int DIST_W = dist_width(DATA_WIDTH, N);
  localparam int BASE_W = KS_WIDTH + $clog2(N + 1);
  localparam int CMP_W = DIST_W + BASE_W + 8;
  localparam int RC_W = $clog2(PATCH_H + 1);
  localparam int WP_W = DATA_WIDTH + WEIGHT_WIDTH;
  logic [RC_W-1:0] row_cnt_q, row_cnt_d;
  logic [DIST_W-1:0] acc_q, acc_d, row_ssd;
  logic [BASE_W-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic m_valid_q, m_valid_d;
  logic [WEIGHT_WIDTH-1:0] m_weight_q, lut_w, ovr_w;
  logic [WP_W-1:0] m_wpix_q, wpix_d;
  logic [DIST_W-1:0] m_dist_q;
  logic [CMP_W-1:0] g;
  logic accept, first, last;
  nlm_row_ssd #(.DATA_WIDTH(DATA_WIDTH), .PATCH_W(PATCH_W), .OUT_W(DIST_W)) u_ssd (
    .ref_row_i(s_ref_row),
    .srh_row_i(s_srh_row),
    .ssd_o(row_ssd)
  );
  assign s_ready = ~rst & (~m_valid_q | m_ready);
  assign accept = s_valid & s_ready;
  assign first = row_cnt_q == '0;
  assign last = row_cnt_q == RC_W'(PATCH_H - 1);
  // On the first beat the fresh sigma and pixel are used directly so a one-row patch still works.
  always_comb begin
    acc_d = first ? row_ssd : acc_q + row_ssd;
    base_d = first ? BASE_W'(cfg_ksigma) * BASE_W'(N) : base_q;
    pix_d = first ? s_pix : pix_q;
    row_cnt_d = last ? '0 : row_cnt_q + 1'b1;
    g = CMP_W'(acc_d) * CMP_W'(5);
    lut_w = '0;
    for (int k = LUT_STEPS - 1; k >= 0; k--)
      lut_w = (g <= CMP_W'(base_d) * CMP_W'(thr_ofs(k))) ? WEIGHT_WIDTH'(WTAB[k]) : lut_w;
    ovr_w = CENTER_MODE == 1 ? '0 : CENTER_MODE == 2 ? WEIGHT_WIDTH'(255) : lut_w;
    wpix_d = WP_W'(ovr_w) * WP_W'(pix_d);
    m_valid_d = (accept & last) | (m_valid_q & ~m_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q <= '0;
      acc_q <= '0;
      base_q <= '0;
      pix_q <= '0;
      m_valid_q <= 1'b0;
      m_weight_q <= '0;
      m_wpix_q <= '0;
      m_dist_q <= '0;
    end else begin
      if (accept) begin
        row_cnt_q <= row_cnt_d;
        acc_q <= acc_d;
        base_q <= base_d;
        pix_q <= pix_d;
      end
      m_valid_q <= m_valid_d;
      if (accept & last) begin
        m_weight_q <= ovr_w;
        m_wpix_q <= wpix_d;
        m_dist_q <= acc_d;
      end
    end
  end
  assign m_valid = m_valid_q;
  assign m_weight = m_weight_q;
  assign m_wpix = m_wpix_q;
  assign m_dist = m_dist_q;
endmodule

// File: tb/tb_nlm_pe_stream.sv
// tb_nlm_pe_stream: directed and randomized checks of the NLM PE against a behavioural model.
module tb_nlm_pe_stream;
  localparam int DW = 12, PW = 5, PH = 5, RW = PW * DW;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] ks;
  logic s_valid, m_ready;
  logic [RW-1:0] rr, sr;
  logic [DW-1:0] pix;
  logic s_ready0, s_ready1, mv0, mv1;
  logic [7:0] w0, w1;
  logic [19:0] wp0, wp1;
  logic [28:0] d0, d1;
  nlm_pe_stream #(.CENTER_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .cfg_ksigma(ks), .s_valid(s_valid), .s_ready(s_ready0),
    .s_ref_row(rr), .s_srh_row(sr), .s_pix(pix), .m_valid(mv0), .m_ready(m_ready),
    .m_weight(w0), .m_wpix(wp0), .m_dist(d0)
  );
  nlm_pe_stream #(.CENTER_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_ksigma(ks), .s_valid(s_valid), .s_ready(s_ready1),
    .s_ref_row(rr), .s_srh_row(sr), .s_pix(pix), .m_valid(mv1), .m_ready(m_ready),
    .m_weight(w1), .m_wpix(wp1), .m_dist(d1)
  );
  int checks = 0, errors = 0;
  int wtab [16] = '{255, 251, 236, 201, 163, 125, 93, 67, 47, 33, 22, 15, 10, 7, 5, 3};
  bit ev;
  longint ed, ew, ewp, acc, base, mpix;
  int row;
  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask
  function automatic longint rssd(input logic [RW-1:0] r, input logic [RW-1:0] s);
    longint t = 0;
    for (int i = 0; i < PW; i++) begin
      longint a = longint'(r[i*DW +: DW]);
      longint b = longint'(s[i*DW +: DW]);
      t += (a - b) * (a - b);
    end
    return t;
  endfunction
  function automatic longint wlut(input longint d, input longint b);
    for (int k = 0; k < 16; k++) if (5 * d <= b * (10 + k)) return longint'(wtab[k]);
    return 0;
  endfunction
  function automatic logic [RW-1:0] rowv(input int v);
    logic [RW-1:0] r;
    for (int i = 0; i < PW; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction
  task automatic step(input bit sv, input logic [RW-1:0] r_row, input logic [RW-1:0] s_row,
                      input logic [DW-1:0] p, input logic [15:0] k, input bit mr);
    bit take;
    @(negedge clk);
    chk("m_valid", longint'(mv0), longint'(ev));
    chk("m_valid_cm1", longint'(mv1), longint'(ev));
    if (ev) begin
      chk("m_dist", longint'(d0), ed);
      chk("m_weight", longint'(w0), ew);
      chk("m_wpix", longint'(wp0), ewp);
      chk("m_dist_cm1", longint'(d1), ed);
      chk("m_weight_cm1", longint'(w1), 0);
      chk("m_wpix_cm1", longint'(wp1), 0);
    end
    s_valid = sv; rr = r_row; sr = s_row; pix = p; ks = k; m_ready = mr;
    #1;
    chk("s_ready", longint'(s_ready0), longint'(!ev || mr));
    chk("s_ready_cm1", longint'(s_ready1), longint'(!ev || mr));
    take = sv && (!ev || mr);
    if (ev && mr) ev = 0;
    if (take) begin
      if (row == 0) begin
        acc = rssd(r_row, s_row); base = 25 * longint'(k); mpix = longint'(p);
      end else acc += rssd(r_row, s_row);
      if (row == PH - 1) begin
        ev = 1; ed = acc; ew = wlut(acc, base); ewp = ew * mpix; row = 0;
      end else row++;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    #1;
    chk("rst_s_ready", longint'(s_ready0), 0);
    chk("rst_m_valid", longint'(mv0), 0);
    chk("rst_m_weight", longint'(w0), 0);
    chk("rst_m_wpix", longint'(wp0), 0);
    chk("rst_m_dist", longint'(d0), 0);
    @(posedge clk);
    #1;
    chk("rst_s_ready_hold", longint'(s_ready1), 0);
    rst = 1'b0; ev = 0; row = 0;
  endtask
  task automatic patch(input int rv, input int sv_, input int p, input int k);
    repeat (PH) step(1, rowv(rv), rowv(sv_), DW'(p), 16'(k), 1);
  endtask
  task automatic lit(input string n, input longint d, input longint w, input longint wp);
    @(posedge clk);
    #1;
    chk({n, "_valid"}, longint'(mv0), 1);
    chk({n, "_dist"}, longint'(d0), d);
    chk({n, "_weight"}, longint'(w0), w);
    chk({n, "_wpix"}, longint'(wp0), wp);
  endtask
  initial begin
    s_valid = 0; rr = '0; sr = '0; pix = '0; ks = 16'd400; m_ready = 1; ev = 0; row = 0;
    do_reset();
    patch(500, 500, 100, 400); lit("ident", 0, 255, 25500);
    chk("cm1_weight", longint'(w1), 0);
    chk("cm1_wpix", longint'(wp1), 0);
    patch(200, 171, 100, 400); lit("d29", 21025, 251, 25100);
    patch(300, 237, 77, 400); lit("d63", 99225, 0, 0);
    patch(4095, 0, 9, 400); lit("max", 419225625, 0, 0);
    repeat (3) step(1, rowv(10), rowv(12), 50, 400, 0);
    chk("stall_s_ready", longint'(s_ready0), 0);
    chk("stall_dist", longint'(d0), 419225625);
    repeat (PH) step(1, rowv(10), rowv(12), 50, 400, 1);
    lit("after_stall", 100, 255, 12750);
    repeat (2) step(1, rowv(7), rowv(9), 1, 400, 1);
    do_reset();
    patch(600, 600, 20, 400); lit("post_rst", 0, 255, 5100);
    repeat (3) step(1, rowv(200), rowv(171), 100, 400, 1);
    repeat (2) step(1, rowv(200), rowv(171), 100, 100, 1);
    lit("ks_old", 21025, 251, 25100);
    patch(200, 171, 100, 100); lit("ks_new", 21025, 0, 0);
    repeat (800) begin
      logic [RW-1:0] r, s;
      logic [15:0] k;
      int sel;
      if ($urandom % 250 == 0) do_reset();
      for (int i = 0; i < PW; i++) begin
        int a = int'($urandom_range(0, 4095));
        int d = int'($urandom_range(0, 40));
        r[i*DW +: DW] = DW'(a);
        s[i*DW +: DW] = DW'(a >= d ? a - d : a + d);
      end
      sel = int'($urandom % 4);
      k = sel == 0 ? 16'd100 : sel == 1 ? 16'd400 : sel == 2 ? 16'd1000 : 16'($urandom);
      step($urandom % 4 != 0, r, s, DW'($urandom), k, $urandom % 3 != 0);
    end
    repeat (3) step(0, '0, '0, '0, 16'd400, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
